rx_agc_module: RTL
==================

Name: rx_agc_module

Overview:
Feedback digital AGC directly downstream of the Rx filter chain.
- Consumes 25 Msps packed I/Q words plus a one-cycle valid strobe on the 200 MHz logic clock.
- Scales each sample by a 12-bit gain and saturates it to 16 bits per rail.
- Measures post-gain |I|+|Q| over fixed windows and steps the gain toward a target level, using a two-state acquire/track loop with a lock indication.

Parameters:
WIN_LOG2, 6, averaging window = 2^WIN_LOG2 output samples
TARGET, 4000, desired mean |I|+|Q| (unsigned, output LSBs)
HYST, 100, in-band half-width around TARGET
STEP_ACQ, 32, gain step in ACQUIRE
STEP_TRK, 4, gain step in TRACK
LOCK_CNT, 4, consecutive in-band (ACQUIRE) or out-of-band (TRACK) windows needed to change state
GAIN_INIT, 256, reset gain (unsigned Q4.8; 256 = 1.0)
GAIN_MIN, 16, lower gain clamp
GAIN_MAX, 4095, upper gain clamp
DC_SHIFT, 10, DC-tracking leak shift (only used with the optional feature)

Ports:
logic_clk_in  in  1  200 MHz logic clock; the only clock
logic_rst_in  in  1  reset, synchronous, active-high
data_agc_in  in  32  [15:0] I, [31:16] Q, two's complement
agc_nd_in  in  1  input sample valid, one-cycle strobe
agc_freeze_in  in  1  1 = hold gain and state; windows keep running
data_agc_out  out  32  scaled I/Q, same packing as the input
agc_rdy_out  out  1  output valid strobe
agc_gain_out  out  12  current gain
agc_lock_out  out  1  1 while in TRACK
agc_power_out  out  17  last completed window mean |I|+|Q|

Behaviour:
- Reset state: data_agc_out=0, agc_rdy_out=0, agc_gain_out=GAIN_INIT, agc_lock_out=0, agc_power_out=0. FSM=ACQUIRE; window counter, accumulator and run counter all 0. In-flight samples are dropped, so no rdy is issued for samples accepted before reset.
- Datapath, 3-cycle latency (agc_nd_in at cycle n gives agc_rdy_out at n+3):
  - S1: register the input.
  - S2: signed 16 x unsigned 12 multiply per rail. Gain is sampled in this cycle.
  - S3: round half-up, (p+128)>>8, then symmetric saturation: >32767 becomes 0x7FFF, <-32767 becomes 0x8001.
- Every cycle with agc_rdy_out=1:
  - add |I_out|+|Q_out| (17-bit unsigned) to the accumulator; width is 17+WIN_LOG2.
  - increment the window counter; it wraps at 2^WIN_LOG2-1.
- Window end is the rdy cycle where the counter = 2^WIN_LOG2-1. On the next cycle:
  - avg = acc>>WIN_LOG2 is loaded into agc_power_out; the accumulator restarts from 0.
  - Classification: HIGH if avg>TARGET+HYST, LOW if avg<TARGET-HYST, else IN.
  - Unless frozen: HIGH gives gain-=step and LOW gives gain+=step, where step is STEP_ACQ in ACQUIRE and STEP_TRK in TRACK. The result is clamped to [GAIN_MIN,GAIN_MAX]; no wrap-around.
  - The new gain takes effect from the following cycle's S2.
- FSM:
  - ACQUIRE: count consecutive IN windows; an out-of-band window clears the count. At LOCK_CNT go to TRACK and clear the count.
  - TRACK: count consecutive non-IN windows; an IN window clears the count. At LOCK_CNT go to ACQUIRE and clear the count.
  - agc_lock_out is registered and follows the state in the same cycle as the transition.
- Freeze: gain, FSM and run counter are held. agc_power_out still updates. A freeze asserted on a window-end evaluation cycle blocks that update.
- Back-to-back agc_nd_in is supported at full rate. A sample already in S2 during a gain update uses the old gain.

Optional Feature:
RX_AGC_DC_REMOVE_EN
- Defined: a DC-removal stage is inserted before S1, adding one cycle (latency 4).
  - Per valid sample and per rail: dc += (x-dc)>>>DC_SHIFT, using a 16+DC_SHIFT-bit accumulator.
  - Output is x-dc, saturated to 0x7FFF/0x8001. DC state resets to 0.
- Undefined: no stage is inserted, latency is 3, and the data path is bit-exact to the description above.

Test Plan:
1. Reset, then one sample I=1000,Q=-1000 with gain 256 -> exactly 3 cycles later data_agc_out=0xFC18_03E8, agc_rdy_out pulses for 1 cycle.
2. Constant I=Q=1000 every 8 clocks, default params -> agc_gain_out steps 256,288,...,512, one step per 64-sample window. agc_power_out settles at 4000. agc_lock_out rises at the end of window 12.
3. After lock, input drops to I=Q=500 -> TRACK steps +4 per window. After 4 LOW windows the FSM returns to ACQUIRE (lock=0) and the step becomes 32.
4. I=20000,Q=-20000 with gain forced to 512 via step 2 settling -> out I=0x7FFF, Q=0x8001. Gain decreases, and I=Q=0 input drives gain to clamp 4095 with no wrap.
5. agc_freeze_in=1 across three window ends while the level is LOW -> gain and lock unchanged, agc_power_out updates each window.
6. logic_rst_in pulsed while 2 samples are in flight -> no agc_rdy_out for them, and all outputs equal their reset values on the cycle after reset.

Source files
------------

// File: rtl/rx_agc_module.sv
// Feedback AGC: scales packed I/Q by a 12-bit gain, measures windowed |I|+|Q|, steps gain toward TARGET.
// Latency 3 cycles agc_nd_in -> agc_rdy_out (4 with `define RX_AGC_DC_REMOVE_EN, which adds DC removal).
// No backpressure: accepts a sample every cycle, output is a one-cycle strobe.
module rx_agc_module #(
  parameter int WIN_LOG2  = 6,
  parameter int TARGET    = 4000,
  parameter int HYST      = 100,
  parameter int STEP_ACQ  = 32,
  parameter int STEP_TRK  = 4,
  parameter int LOCK_CNT  = 4,
  parameter int GAIN_INIT = 256,
  parameter int GAIN_MIN  = 16,
  parameter int GAIN_MAX  = 4095,
  parameter int DC_SHIFT  = 10
) (
  input  logic        logic_clk_in,
  input  logic        logic_rst_in,
  input  logic [31:0] data_agc_in,
  input  logic        agc_nd_in,
  input  logic        agc_freeze_in,
  output logic [31:0] data_agc_out,
  output logic        agc_rdy_out,
  output logic [11:0] agc_gain_out,
  output logic        agc_lock_out,
  output logic [16:0] agc_power_out
);

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] i;
  } iq_t;

  localparam logic [0:0] ST_ACQUIRE = 1'b0;
  localparam logic [0:0] ST_TRACK   = 1'b1;

  localparam int ACC_W = 17 + WIN_LOG2;
  localparam int RUN_W = $clog2(LOCK_CNT + 1);

  localparam logic [16:0]        HI_THR = 17'(TARGET + HYST);
  localparam logic [16:0]        LO_THR = 17'(TARGET - HYST);
  localparam logic signed [13:0] STEP_A = 14'(STEP_ACQ);
  localparam logic signed [13:0] STEP_T = 14'(STEP_TRK);
  localparam logic signed [13:0] GMIN_S = 14'(GAIN_MIN);
  localparam logic signed [13:0] GMAX_S = 14'(GAIN_MAX);
  localparam logic [11:0]        GMIN12 = 12'(GAIN_MIN);
  localparam logic [11:0]        GMAX12 = 12'(GAIN_MAX);
  localparam logic [11:0]        GINIT  = 12'(GAIN_INIT);

  if (WIN_LOG2 < 1 || WIN_LOG2 > 12) begin : g_bad_win
    $error("rx_agc_module: WIN_LOG2 out of range");
  end
  if (GAIN_MIN > GAIN_INIT || GAIN_INIT > GAIN_MAX || GAIN_MAX > 4095) begin : g_bad_gain
    $error("rx_agc_module: gain limits inconsistent");
  end
  if (DC_SHIFT < 1 || DC_SHIFT > 15) begin : g_bad_dc
    $error("rx_agc_module: DC_SHIFT out of range");
  end

  // Symmetric saturation: the result never takes the value 0x8000.
  function automatic logic [15:0] sat16(input logic signed [29:0] v);
    if (v > 30'sd32767)       sat16 = 16'h7FFF;
    else if (v < -30'sd32767) sat16 = 16'h8001;
    else                      sat16 = v[15:0];
  endfunction

  function automatic logic [15:0] round_sat(input logic signed [28:0] p);
    logic signed [29:0] r;
    r = {p[28], p} + 30'sd128;
    round_sat = sat16(r >>> 8);
  endfunction

  function automatic logic [15:0] abs16(input logic [15:0] v);
    abs16 = v[15] ? (~v + 16'd1) : v;
  endfunction

  iq_t  front_dat;
  logic front_vld;

`ifdef RX_AGC_DC_REMOVE_EN
  localparam int DCW = 16 + DC_SHIFT;

  iq_t                   in_iq;
  iq_t                   dc_dat;
  logic                  dc_vld;
  logic signed [DCW-1:0] dc_acc_i, dc_acc_q;
  logic signed [15:0]    dc_i, dc_q;
  logic signed [16:0]    dif_i, dif_q;

  // Accumulator holds dc scaled by 2^DC_SHIFT, so acc += x - dc is the leaky update.
  assign in_iq = data_agc_in;
  assign dc_i  = 16'(dc_acc_i >>> DC_SHIFT);
  assign dc_q  = 16'(dc_acc_q >>> DC_SHIFT);
  assign dif_i = {in_iq.i[15], in_iq.i} - {dc_i[15], dc_i};
  assign dif_q = {in_iq.q[15], in_iq.q} - {dc_q[15], dc_q};

  always_ff @(posedge logic_clk_in) begin
    if (logic_rst_in) begin
      dc_acc_i <= '0;
      dc_acc_q <= '0;
      dc_dat   <= '0;
      dc_vld   <= 1'b0;
    end else begin
      dc_vld <= agc_nd_in;
      if (agc_nd_in) begin
        dc_acc_i <= dc_acc_i + {{(DCW-17){dif_i[16]}}, dif_i};
        dc_acc_q <= dc_acc_q + {{(DCW-17){dif_q[16]}}, dif_q};
        dc_dat.i <= sat16({{13{dif_i[16]}}, dif_i});
        dc_dat.q <= sat16({{13{dif_q[16]}}, dif_q});
      end
    end
  end

  assign front_dat = dc_dat;
  assign front_vld = dc_vld;
`else
  assign front_dat = data_agc_in;
  assign front_vld = agc_nd_in;
`endif

  // Datapath: S1 register, S2 multiply, S3 round/saturate
  iq_t               s1_dat;
  logic              s1_vld;
  logic signed [28:0] s2_prod_i, s2_prod_q;
  logic              s2_vld;
  logic signed [28:0] prod_i_c, prod_q_c, gain_x;
  logic [11:0]       gain;

  assign gain_x   = {17'd0, gain};
  assign prod_i_c = 29'($signed(s1_dat.i)) * gain_x;
  assign prod_q_c = 29'($signed(s1_dat.q)) * gain_x;

  always_ff @(posedge logic_clk_in) begin
    if (logic_rst_in) begin
      s1_dat       <= '0;
      s1_vld       <= 1'b0;
      s2_prod_i    <= '0;
      s2_prod_q    <= '0;
      s2_vld       <= 1'b0;
      data_agc_out <= '0;
      agc_rdy_out  <= 1'b0;
    end else begin
      s1_vld <= front_vld;
      if (front_vld) s1_dat <= front_dat;
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_prod_i <= prod_i_c;
        s2_prod_q <= prod_q_c;
      end
      agc_rdy_out <= s2_vld;
      if (s2_vld) data_agc_out <= {round_sat(s2_prod_q), round_sat(s2_prod_i)};
    end
  end

  // Window power measurement
  iq_t                 out_iq;
  logic [16:0]         mag;
  logic [ACC_W-1:0]    acc;
  logic [WIN_LOG2-1:0] win_cnt;
  logic                win_end;
  logic [16:0]         avg;

  assign out_iq = data_agc_out;
  assign mag    = {1'b0, abs16(out_iq.i)} + {1'b0, abs16(out_iq.q)};
  assign avg    = 17'(acc >> WIN_LOG2);

  always_ff @(posedge logic_clk_in) begin
    if (logic_rst_in) begin
      acc     <= '0;
      win_cnt <= '0;
      win_end <= 1'b0;
    end else begin
      win_end <= agc_rdy_out && (win_cnt == '1);
      if (agc_rdy_out) win_cnt <= win_cnt + 1'b1;
      // A sample arriving on the evaluation cycle starts the next window.
      if (win_end)          acc <= agc_rdy_out ? ACC_W'(mag) : '0;
      else if (agc_rdy_out) acc <= acc + ACC_W'(mag);
    end
  end

  // Gain loop and acquire/track FSM, evaluated on the cycle after a window end
  logic [0:0]        state, state_nxt;
  logic [RUN_W-1:0]  run_cnt, run_nxt;
  logic [11:0]       gain_nxt;
  logic signed [13:0] step, g_up, g_dn;
  logic              is_high, is_low, is_in;

  always_comb begin
    is_high   = avg > HI_THR;
    is_low    = avg < LO_THR;
    is_in     = !is_high && !is_low;
    step      = (state == ST_TRACK) ? STEP_T : STEP_A;
    g_up      = $signed({2'b00, gain}) + step;
    g_dn      = $signed({2'b00, gain}) - step;
    gain_nxt  = gain;
    if (is_high)     gain_nxt = (g_dn < GMIN_S) ? GMIN12 : g_dn[11:0];
    else if (is_low) gain_nxt = (g_up > GMAX_S) ? GMAX12 : g_up[11:0];

    state_nxt = state;
    run_nxt   = run_cnt;
    if ((state == ST_ACQUIRE) == is_in) begin
      if (run_cnt == RUN_W'(LOCK_CNT - 1)) begin
        state_nxt = (state == ST_ACQUIRE) ? ST_TRACK : ST_ACQUIRE;
        run_nxt   = '0;
      end else begin
        run_nxt = run_cnt + 1'b1;
      end
    end else begin
      run_nxt = '0;
    end
  end

  always_ff @(posedge logic_clk_in) begin
    if (logic_rst_in) begin
      gain          <= GINIT;
      state         <= ST_ACQUIRE;
      run_cnt       <= '0;
      agc_lock_out  <= 1'b0;
      agc_power_out <= '0;
    end else if (win_end) begin
      agc_power_out <= avg;
      if (!agc_freeze_in) begin
        gain         <= gain_nxt;
        state        <= state_nxt;
        run_cnt      <= run_nxt;
        agc_lock_out <= (state_nxt == ST_TRACK);
      end
    end
  end

  assign agc_gain_out = gain;

endmodule
